// File: rtl/fetch_unit.sv
// Instruction fetch: one memory read per new PC value, result handed to decode.
// Latency: new PC in IDLE at N -> mem_req at N+1; ack at N+1 -> instr_valid at N+2.
// Back-pressure: instr held in HOLD until instr_ready; PC changes are ignored until IDLE.
module fetch_unit #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_DROP,
      S_HOLD,
      S_ERR
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              have_pc, have_pc_nxt;
   logic [7:0]        tcnt, tcnt_nxt;
   logic [ADDR_W-1:0] last_pc;
   logic              load_addr;
   logic              capture;
   logic              need_fetch;

   // last_pc doubles as the request address; it only changes when a fetch starts
   assign need_fetch  = !have_pc || (pc[ADDR_W-1:0] != last_pc);
   assign mem_addr    = last_pc;
   assign mem_req     = (state == S_REQ) || (state == S_DROP);
   assign instr_valid = (state == S_HOLD);
   assign fetch_err   = (state == S_ERR);

   // Next-state logic: fetch sequencing, flush handling and request timeout
   always_comb begin
      state_nxt   = state;
      have_pc_nxt = have_pc;
      tcnt_nxt    = tcnt;
      load_addr   = 1'b0;
      capture     = 1'b0;
      case (state)
         S_IDLE: begin
            // a flush only forgets the PC so the jump target is always refetched
            if (flush) begin
               have_pc_nxt = 1'b0;
            end else if (need_fetch) begin
               load_addr   = 1'b1;
               have_pc_nxt = 1'b1;
               tcnt_nxt    = 8'd0;
               state_nxt   = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               if (flush) begin
                  have_pc_nxt = 1'b0;
                  state_nxt   = S_IDLE;
               end else begin
                  capture   = 1'b1;
                  state_nxt = S_HOLD;
               end
            end else if (tcnt == TMO_LAST) begin
               state_nxt = S_ERR;
            end else begin
               tcnt_nxt = tcnt + 8'd1;
               // the request cannot be withdrawn, so wait out its ack in DROP
               if (flush) begin
                  have_pc_nxt = 1'b0;
                  state_nxt   = S_DROP;
               end
            end
         end
         S_DROP: begin
            // tcnt keeps running from REQ so the total wait stays bounded
            if (mem_ack) begin
               state_nxt = S_IDLE;
            end else if (tcnt == TMO_LAST) begin
               state_nxt = S_ERR;
            end else begin
               tcnt_nxt = tcnt + 8'd1;
            end
         end
         S_HOLD: begin
            if (flush) begin
               have_pc_nxt = 1'b0;
               state_nxt   = S_IDLE;
            end else if (instr_ready) begin
               state_nxt = S_IDLE;
            end
         end
         S_ERR: begin
            state_nxt = S_ERR;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         have_pc <= 1'b0;
         tcnt    <= 8'd0;
      end else begin
         state   <= state_nxt;
         have_pc <= have_pc_nxt;
         tcnt    <= tcnt_nxt;
      end
   end

   // Datapath: latch the fetch address and capture the returned instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         last_pc  <= '0;
         instr    <= '0;
         instr_pc <= '0;
      end else begin
         if (load_addr) begin
            last_pc <= pc[ADDR_W-1:0];
         end
         if (capture) begin
            instr    <= mem_rdata;
            instr_pc <= last_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written flush/timeout
// sequences, then random PC/flush/memory/decode traffic against a
// transaction-level scoreboard.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .fetch_err  (fetch_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one directed cycle: inputs for the cycle, outputs expected after its edge
   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        flush;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
      logic        e_err;
   } vec_t;

   vec_t vt[$];

   task automatic row(input logic r, input logic [31:0] p, input logic f, input logic a,
                      input logic [31:0] d, input logic rd, input logic er,
                      input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                      input logic [31:0] ep, input logic ee);
      vec_t v;
      v.rst = r; v.pc = p; v.flush = f; v.ack = a; v.rdata = d; v.rdy = rd;
      v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_ipc = ep; v.e_err = ee;
      vt.push_back(v);
   endtask

   task automatic step(input logic r, input logic [31:0] p, input logic f, input logic a,
                       input logic [31:0] d, input logic rd);
      rst = r; pc = p; flush = f; mem_ack = a; mem_rdata = d; instr_ready = rd;
      @(posedge clk);
      #1;
   endtask

   // scoreboard types for the random phase
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] pc_nxt, pc_prev, req_addr, last_req_addr, tgt;
   logic        req_active, req_drop, have_last, flush_since;
   int          dly, cnt, stepc, hi;

   initial begin
      rst = 1'b1; pc = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;

      // ---------------- directed vector table ----------------
      //   rst pc            fl ack rdata          rdy | req addr          vld instr          ipc           err
      row(1, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(1, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'h0,        0, 1, 32'h00500093, 0,   0, 32'h0,        1, 32'h00500093, 32'h0,        0);
      row(0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'h1,        0, 0, 32'h0,        1,   1, 32'h1,        0, 32'h0,        32'h0,        0);
      row(0, 32'h1,        0, 1, 32'h11,       1,   0, 32'h0,        1, 32'h11,       32'h1,        0);
      row(0, 32'h1,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'h1,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      // back-pressure: ready low for 6 clocks while pc moves 5 -> 6
      row(0, 32'h5,        0, 0, 32'h0,        0,   1, 32'h5,        0, 32'h0,        32'h0,        0);
      row(0, 32'h5,        0, 1, 32'h55,       0,   0, 32'h0,        1, 32'h55,       32'h5,        0);
      row(0, 32'h5,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h55,       32'h5,        0);
      row(0, 32'h6,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h55,       32'h5,        0);
      row(0, 32'h6,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h55,       32'h5,        0);
      row(0, 32'h6,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h55,       32'h5,        0);
      row(0, 32'h6,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h55,       32'h5,        0);
      row(0, 32'h6,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'h6,        0, 0, 32'h0,        0,   1, 32'h6,        0, 32'h0,        32'h0,        0);
      row(0, 32'h6,        0, 1, 32'h66,       0,   0, 32'h0,        1, 32'h66,       32'h6,        0);
      row(0, 32'h6,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      // same-value jump while holding pc 7 -> refetch of 7
      row(0, 32'h7,        0, 0, 32'h0,        0,   1, 32'h7,        0, 32'h0,        32'h0,        0);
      row(0, 32'h7,        0, 1, 32'h77,       0,   0, 32'h0,        1, 32'h77,       32'h7,        0);
      row(0, 32'h7,        1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'h7,        0, 0, 32'h0,        0,   1, 32'h7,        0, 32'h0,        32'h0,        0);
      row(0, 32'h7,        0, 1, 32'h78,       0,   0, 32'h0,        1, 32'h78,       32'h7,        0);
      row(0, 32'h7,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      // all-ones address
      row(0, 32'hFFFFFFFF, 0, 0, 32'h0,        0,   1, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        0);
      row(0, 32'hFFFFFFFF, 0, 1, 32'hAB,       0,   0, 32'h0,        1, 32'hAB,       32'hFFFFFFFF, 0);
      row(0, 32'hFFFFFFFF, 0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,        0);
      row(0, 32'hFFFFFFFF, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0);

      @(negedge clk);
      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].rst, vt[i].pc, vt[i].flush, vt[i].ack, vt[i].rdata, vt[i].rdy);
         chk($sformatf("vec%0d.mem_req", i), mem_req, vt[i].e_req);
         chk($sformatf("vec%0d.instr_valid", i), instr_valid, vt[i].e_vld);
         chk($sformatf("vec%0d.fetch_err", i), fetch_err, vt[i].e_err);
         if (vt[i].e_req || vt[i].rst)
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, vt[i].e_addr);
         if (vt[i].e_vld || vt[i].rst) begin
            chk($sformatf("vec%0d.instr", i), instr, vt[i].e_instr);
            chk($sformatf("vec%0d.instr_pc", i), instr_pc, vt[i].e_ipc);
         end
      end

      // ---------------- flush during REQ, late ack discarded ----------------
      step(1, 32'h10, 0, 0, 32'h0, 0);
      step(0, 32'h10, 0, 0, 32'h0, 0);
      chk("drop.req0", mem_req, 1'b1);
      chk("drop.addr0", mem_addr, 32'h10);
      step(0, 32'h10, 1, 0, 32'h0, 0);
      chk("drop.req_held", mem_req, 1'b1);
      step(0, 32'h40, 0, 0, 32'h0, 0);
      step(0, 32'h40, 0, 0, 32'h0, 0);
      chk("drop.addr_held", mem_addr, 32'h10);
      chk("drop.no_valid", instr_valid, 1'b0);
      step(0, 32'h40, 0, 1, 32'hDEADBEEF, 1);
      chk("drop.req_done", mem_req, 1'b0);
      chk("drop.discarded", instr_valid, 1'b0);
      step(0, 32'h40, 0, 0, 32'h0, 0);
      chk("drop.refetch_req", mem_req, 1'b1);
      chk("drop.refetch_addr", mem_addr, 32'h40);
      step(0, 32'h40, 0, 1, 32'h40400000, 0);
      chk("drop.valid", instr_valid, 1'b1);
      chk("drop.instr", instr, 32'h40400000);
      chk("drop.instr_pc", instr_pc, 32'h40);
      step(0, 32'h40, 0, 0, 32'h0, 1);
      chk("drop.accepted", instr_valid, 1'b0);

      // ---------------- memory timeout ----------------
      step(1, 32'h20, 0, 0, 32'h0, 0);
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, 32'h20, 0, 0, 32'h0, 1);
         if (mem_req) hi++;
      end
      chk("tmo.req_cycles", hi, 15);
      chk("tmo.req_low", mem_req, 1'b0);
      chk("tmo.err", fetch_err, 1'b1);
      step(0, 32'h21, 1, 1, 32'h1234, 1);
      step(0, 32'h22, 0, 1, 32'h1234, 1);
      chk("tmo.err_sticky", fetch_err, 1'b1);
      chk("tmo.no_valid", instr_valid, 1'b0);
      step(1, 32'h30, 0, 0, 32'h0, 0);
      chk("tmo.rst_clears", fetch_err, 1'b0);
      step(0, 32'h30, 0, 0, 32'h0, 0);
      chk("tmo.restart_req", mem_req, 1'b1);
      chk("tmo.restart_addr", mem_addr, 32'h30);

      // ---------------- random traffic vs scoreboard ----------------
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
      pc = 32'h100; pc_nxt = 32'h100;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      req_active = 0; req_drop = 0; have_last = 0; flush_since = 0;
      req_addr = '0; last_req_addr = '0; dly = 0; cnt = 0; stepc = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         pc_prev = pc;
         pc = pc_nxt;
         chk("rnd.fetch_err", fetch_err, 1'b0);
         // request tracking: start address, no redundant refetch, stable address
         if (mem_req && !req_active) begin
            chk("rnd.req_addr", mem_addr, pc_prev);
            chk("rnd.dup_fetch", have_last && (mem_addr == last_req_addr) && !flush_since, 1'b0);
            req_active = 1; req_addr = mem_addr; req_drop = 0;
            last_req_addr = mem_addr; have_last = 1; flush_since = 0;
            dly = $urandom_range(0, 3); cnt = 0;
         end else if (mem_req) begin
            chk("rnd.addr_stable", mem_addr, req_addr);
         end
         // inputs for this cycle
         flush       = ($urandom_range(0, 11) == 0);
         instr_ready = ($urandom_range(0, 9) < 7);
         mem_ack     = mem_req && (cnt == dly);
         mem_rdata   = $urandom;
         if (mem_req) cnt++;
         // decode side: exactly the unconsumed, unflushed fetch is presented
         chk("rnd.valid", instr_valid, q.size() != 0);
         if (instr_valid && q.size() != 0) begin
            chk("rnd.instr", instr, q[0].data);
            chk("rnd.instr_pc", instr_pc, q[0].addr);
            if (flush || instr_ready) void'(q.pop_front());
         end
         // memory side: acked, unflushed data becomes the next presented instruction
         if (mem_req) begin
            if (flush) req_drop = 1;
            if (mem_ack) begin
               if (!req_drop) q.push_back('{addr: req_addr, data: mem_rdata});
               req_active = 0;
            end
         end
         if (flush) flush_since = 1;
         // PC stage: jump on flush, otherwise advance every 4 clocks
         if (flush) begin
            case ($urandom_range(0, 3))
               0: tgt = pc;
               1: tgt = pc + 32'($urandom_range(1, 8));
               2: tgt = $urandom;
               default: tgt = 32'hFFFFFFFF;
            endcase
            pc_nxt = tgt;
            stepc  = 0;
         end else begin
            stepc++;
            if (stepc == 4) begin
               pc_nxt = pc + 32'd1;
               stepc  = 0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Watches the word-addressed PC. The PC advances by 1 every 4 clocks, or loads a jump target.
- On each new PC value, issues one read to instruction memory over a req/ack handshake and captures the returned instruction word.
- Presents the instruction to decode with a valid/ready handshake. Handles jump flushes and memory timeouts.

Parameters:
- ADDR_W, 32, width of mem_addr and instr_pc; taken from pc[ADDR_W-1:0].
- DATA_W, 32, instruction word width.
- TIMEOUT, 15, max clocks mem_req may stay high without mem_ack before error; range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  in  32  current word-addressed PC from the PC stage.
- flush  in  1  jump taken this cycle; same timing as the PC stage's jump load.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  memory returns mem_rdata this cycle; ignored unless state is REQ or DROP.
- mem_rdata  in  DATA_W  instruction word; valid only when mem_ack=1.
- instr  out  DATA_W  fetched instruction.
- instr_pc  out  ADDR_W  PC the instruction was fetched from.
- instr_valid  out  1  instr/instr_pc valid for decode.
- instr_ready  in  1  decode accepts instr this cycle.
- fetch_err  out  1  sticky memory-timeout error.

Behaviour:
- Reset: state=IDLE; mem_req=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_err=0; have_pc=0, last_pc=0, tcnt=0. rst has priority over every other input, in any state.
- need_fetch = !have_pc || (pc[ADDR_W-1:0] != last_pc).
- IDLE:
  - If need_fetch: latch mem_addr=last_pc=pc, set have_pc=1, tcnt=0, go to REQ.
  - flush in IDLE: no effect beyond clearing have_pc. A same-value jump target is therefore refetched.
- REQ: mem_req=1; mem_addr held. pc changes here are ignored until the next IDLE.
  - mem_ack & !flush: instr=mem_rdata, instr_pc=mem_addr, instr_valid=1, mem_req=0, go to HOLD.
  - mem_ack & flush: discard data, have_pc=0, mem_req=0, go to IDLE.
  - !mem_ack & flush: have_pc=0, go to DROP; mem_req stays 1 until the outstanding ack.
  - Otherwise tcnt+1. If tcnt reaches TIMEOUT-1 without ack: go to ERR.
- DROP: mem_req=1, waiting only to retire the flushed request.
  - On mem_ack: discard, mem_req=0, go to IDLE.
  - Shares the timeout rule with REQ (tcnt is not reset on REQ->DROP).
- HOLD: instr_valid=1; instr and instr_pc stable.
  - instr_ready=1 (flush=0): instr_valid=0, go to IDLE.
  - flush (ready or not): instr_valid=0, have_pc=0, go to IDLE; the instruction is dropped.
- ERR: mem_req=0, instr_valid=0, fetch_err=1. Exit only via rst.
- Latency, no back-pressure:
  - New pc seen in IDLE at cycle N -> mem_req=1 at N+1.
  - Ack at N+1 -> instr_valid=1 at N+2.
  - Accept at N+2 -> IDLE at N+3.
  - The whole sequence fits inside one 4-clock PC step.
- Only one memory request is outstanding at any time. mem_req never deasserts before ack, except on rst or timeout.
- Address wrap: pc=all-ones is legal; the comparison is pure equality, with no arithmetic.

Test Plan:
1. rst=1 two cycles with pc=0 -> all outputs 0. Release: IDLE->REQ, mem_req=1, mem_addr=0. Ack with 0x00500093 -> instr_valid=1, instr=0x00500093, instr_pc=0 exactly 2 clocks after rst drops.
2. PC stepping 0,1,2 every 4 clocks, memory acks in 1 cycle, instr_ready=1 -> exactly one mem_req per PC value. instr_pc sequence is 0,1,2; never a duplicate fetch of the same PC.
3. Back-pressure: instr_ready=0 for 6 clocks while pc advances 5->6 -> instr/instr_pc held at pc 5 with instr_valid=1. After ready, fetch for 6 issues the next cycle.
4. flush asserted while in REQ, ack delayed 3 clocks, pc jumps to 0x40 -> DROP; the delayed data never appears on instr. A fresh request to 0x40 follows, and instr_pc=0x40.
5. Same-value jump: flush with pc unchanged at 7 while in HOLD -> instr_valid drops the next cycle and address 7 is refetched.
6. mem_ack never asserted, TIMEOUT=15 -> mem_req high exactly 15 clocks, then mem_req=0, fetch_err=1 permanently. rst clears fetch_err and restarts the fetch at the current pc.
